// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and state encoding for the elastic pipeline stage
package pipe_pkg;

    localparam int EXC_W = 5;

    localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
    localparam logic [EXC_W-1:0] EXC_SYS  = 5'd8;
    localparam logic [EXC_W-1:0] EXC_BP   = 5'd9;
    localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
    localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    // Encoding doubles as the occupancy count.
    typedef logic [1:0] pipe_state_t;
    localparam pipe_state_t ST_EMPTY = 2'd0;
    localparam pipe_state_t ST_ONE   = 2'd1;
    localparam pipe_state_t ST_TWO   = 2'd2;

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - one pipe entry (payload + PC/BD/exception sideband) with load and bubble-clear
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int          DATA_W   = 160,
    parameter int          EXC_W    = pipe_pkg::EXC_W,
    parameter logic [31:0] RESET_PC = pipe_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [31:0]       clear_pc,
    input  logic              clear_bd,
    input  logic              load,
    input  logic [DATA_W-1:0] d_data,
    input  logic [31:0]       d_pc,
    input  logic              d_bd,
    input  logic [EXC_W-1:0]  d_exc,
    output logic [DATA_W-1:0] q_data,
    output logic [31:0]       q_pc,
    output logic              q_bd,
    output logic [EXC_W-1:0]  q_exc
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [31:0]       pc;
        logic              bd;
        logic [EXC_W-1:0]  exc;
    } pipe_entry_t;

    pipe_entry_t entry;

    // A cleared entry is a bubble that still carries a meaningful PC/BD.
    always_ff @(posedge clk) begin
        if (!reset) begin
            entry <= '{data: '0, pc: RESET_PC, bd: 1'b0, exc: EXC_W'(EXC_NONE)};
        end else if (clear) begin
            entry <= '{data: '0, pc: clear_pc, bd: clear_bd, exc: EXC_W'(EXC_NONE)};
        end else if (load) begin
            entry <= '{data: d_data, pc: d_pc, bd: d_bd, exc: d_exc};
        end
    end

    assign q_data = entry.data;
    assign q_pc   = entry.pc;
    assign q_bd   = entry.bd;
    assign q_exc  = entry.exc;

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - elastic pipeline stage with 2-entry skid buffer, registered in_ready and flush bubble
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int          DATA_W   = 160,
    parameter int          EXC_W    = pipe_pkg::EXC_W,
    parameter logic [31:0] RESET_PC = pipe_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [31:0]       in_pc,
    input  logic              in_bd,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              flush,
    input  logic [31:0]       flush_pc,
    input  logic              flush_bd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       out_pc,
    output logic              out_bd,
    output logic [EXC_W-1:0]  out_exc,
    output logic [1:0]        occupancy
);

    pipe_state_t state;
    pipe_state_t next_state;

    logic              accept;
    logic              pop;
    logic              head_load;
    logic              skid_load;
    logic [DATA_W-1:0] head_d_data;
    logic [31:0]       head_d_pc;
    logic              head_d_bd;
    logic [EXC_W-1:0]  head_d_exc;
    logic [DATA_W-1:0] skid_data;
    logic [31:0]       skid_pc;
    logic              skid_bd;
    logic [EXC_W-1:0]  skid_exc;

    assign accept    = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign out_valid = (state != ST_EMPTY);
    assign occupancy = state;

    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (accept) next_state = ST_ONE;
                ST_ONE: begin
                    if (accept && !pop)      next_state = ST_TWO;
                    else if (!accept && pop) next_state = ST_EMPTY;
                end
                ST_TWO:   if (pop) next_state = ST_ONE;
                default:  next_state = ST_EMPTY;
            endcase
        end
    end

    // Head refills from the skid when draining TWO, otherwise straight from the input.
    assign head_load = (state == ST_EMPTY && accept)
                     || (state == ST_ONE && accept && pop)
                     || (state == ST_TWO && pop);
    assign skid_load = (state == ST_ONE) && accept && !pop;

    assign head_d_data = (state == ST_TWO) ? skid_data : in_data;
    assign head_d_pc   = (state == ST_TWO) ? skid_pc   : in_pc;
    assign head_d_bd   = (state == ST_TWO) ? skid_bd   : in_bd;
    assign head_d_exc  = (state == ST_TWO) ? skid_exc  : in_exc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= next_state;
            in_ready <= (next_state != ST_TWO);
        end
    end

    pipe_entry_reg #(
        .DATA_W   (DATA_W),
        .EXC_W    (EXC_W),
        .RESET_PC (RESET_PC)
    ) u_head (
        .clk      (clk),
        .reset    (reset),
        .clear    (flush),
        .clear_pc (flush_pc),
        .clear_bd (flush_bd),
        .load     (head_load),
        .d_data   (head_d_data),
        .d_pc     (head_d_pc),
        .d_bd     (head_d_bd),
        .d_exc    (head_d_exc),
        .q_data   (out_data),
        .q_pc     (out_pc),
        .q_bd     (out_bd),
        .q_exc    (out_exc)
    );

    pipe_entry_reg #(
        .DATA_W   (DATA_W),
        .EXC_W    (EXC_W),
        .RESET_PC (32'h0)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .clear    (1'b0),
        .clear_pc (32'h0),
        .clear_bd (1'b0),
        .load     (skid_load),
        .d_data   (in_data),
        .d_pc     (in_pc),
        .d_bd     (in_bd),
        .d_exc    (in_exc),
        .q_data   (skid_data),
        .q_pc     (skid_pc),
        .q_bd     (skid_bd),
        .q_exc    (skid_exc)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - randomized and directed checks of pipe_stage_skid against a queue model
module tb_pipe_stage_skid;

    localparam int          DATA_W = 160;
    localparam int          EXC_W  = 5;
    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [31:0]       in_pc = '0;
    logic              in_bd = 1'b0;
    logic [EXC_W-1:0]  in_exc = '0;
    logic              flush = 1'b0;
    logic [31:0]       flush_pc = '0;
    logic              flush_bd = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [31:0]       out_pc;
    logic              out_bd;
    logic [EXC_W-1:0]  out_exc;
    logic [1:0]        occupancy;

    pipe_stage_skid #(.DATA_W(DATA_W), .EXC_W(EXC_W), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_pc(in_pc), .in_bd(in_bd), .in_exc(in_exc),
        .flush(flush), .flush_pc(flush_pc), .flush_bd(flush_bd),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_pc(out_pc), .out_bd(out_bd), .out_exc(out_exc),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [31:0]       pc;
        logic              bd;
        logic [EXC_W-1:0]  exc;
    } ent_t;

    ent_t              q[$];
    logic [DATA_W-1:0] m_data;
    logic [31:0]       m_pc;
    logic              m_bd;
    logic [EXC_W-1:0]  m_exc;
    int                total = 0;
    int                bad = 0;

    // Model: FIFO of up to two entries; the visible head holds its last value when empty.
    task automatic tick();
        bit   acc;
        bit   pp;
        ent_t e;
        acc = in_valid && (q.size() < 2) && !flush && reset;
        pp  = (q.size() > 0) && out_ready && !flush && reset;
        e   = '{data: in_data, pc: in_pc, bd: in_bd, exc: in_exc};
        @(posedge clk);
        if (!reset) begin
            q.delete();
            m_data = '0; m_pc = RST_PC; m_bd = 1'b0; m_exc = '0;
        end else if (flush) begin
            q.delete();
            m_data = '0; m_pc = flush_pc; m_bd = flush_bd; m_exc = '0;
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(e);
            if (q.size() > 0) begin
                m_data = q[0].data; m_pc = q[0].pc; m_bd = q[0].bd; m_exc = q[0].exc;
            end
        end
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        d = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return d;
    endfunction

    task automatic test_reset();
        reset = 1'b0; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occupancy got=%0d want=0", occupancy); end
        total++; if (out_pc !== RST_PC) begin bad++; $display("FAIL reset_out_pc got=%h want=%h", out_pc, RST_PC); end
        total++; if (out_data !== '0 || out_bd !== 1'b0 || out_exc !== '0) begin
            bad++; $display("FAIL reset_head got data=%h bd=%0b exc=%0d want zeros", out_data, out_bd, out_exc);
        end
        reset = 1'b1;
    endtask

    task automatic test_pass_through();
        in_valid = 1'b1; in_data = {20{8'hA5}}; in_pc = 32'h3004; in_bd = 1'b0; in_exc = '0;
        out_ready = 1'b1;
        total++; if (out_pc !== 32'h3000 || in_ready !== 1'b1) begin
            bad++; $display("FAIL pre_accept got pc=%h rdy=%0b want pc=3000 rdy=1", out_pc, in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (out_valid !== 1'b1 || out_pc !== 32'h3004 || occupancy !== 2'd1) begin
                bad++; $display("FAIL pass_through got v=%0b pc=%h occ=%0d want v=1 pc=3004 occ=1", out_valid, out_pc, occupancy);
            end
            total++; if (out_data !== {20{8'hA5}}) begin bad++; $display("FAIL pass_data got=%h", out_data); end
        end
        in_valid = 1'b0;
        tick();
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL pass_drain got occ=%0d want=0", occupancy); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h3010; in_data = rand_data();
        tick();
        in_pc = 32'h3014; in_data = rand_data();
        tick();
        in_valid = 1'b0;
        total++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_pc !== 32'h3010) begin
            bad++; $display("FAIL bp_full got occ=%0d rdy=%0b pc=%h want occ=2 rdy=0 pc=3010", occupancy, in_ready, out_pc);
        end
        out_ready = 1'b1;
        tick();
        total++; if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_pc !== 32'h3014 || out_data !== q[0].data) begin
            bad++; $display("FAIL bp_first_pop got occ=%0d rdy=%0b pc=%h want occ=1 rdy=1 pc=3014", occupancy, in_ready, out_pc);
        end
        tick();
        total++; if (out_valid !== 1'b0 || out_pc !== 32'h3014) begin
            bad++; $display("FAIL bp_empty got v=%0b pc=%h want v=0 pc=3014 (held)", out_valid, out_pc);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        in_pc = 32'h3030; in_exc = 5'd4; tick();
        in_pc = 32'h3034; in_exc = 5'd5; tick();
        in_pc = 32'h3040; in_exc = 5'd0; in_data = {20{8'h3C}};
        flush = 1'b1; flush_pc = 32'h3020; flush_bd = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b0;
        total++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_state got occ=%0d v=%0b rdy=%0b want 0 0 1", occupancy, out_valid, in_ready);
        end
        total++; if (out_pc !== 32'h3020 || out_bd !== 1'b1 || out_exc !== '0) begin
            bad++; $display("FAIL flush_bubble got pc=%h bd=%0b exc=%0d want pc=3020 bd=1 exc=0", out_pc, out_bd, out_exc);
        end
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h3040 || out_data !== {20{8'h3C}}) begin
            bad++; $display("FAIL flush_replay got v=%0b pc=%h want v=1 pc=3040", out_valid, out_pc);
        end
        out_ready = 1'b1; tick();
    endtask

    task automatic test_exception();
        logic [DATA_W-1:0] d2;
        out_ready = 1'b0; in_valid = 1'b1;
        in_pc = 32'h3050; in_bd = 1'b1; in_exc = 5'd10; in_data = rand_data();
        tick();
        total++; if (out_exc !== 5'd10 || out_bd !== 1'b1 || out_pc !== 32'h3050) begin
            bad++; $display("FAIL exc_head got exc=%0d bd=%0b pc=%h want 10 1 3050", out_exc, out_bd, out_pc);
        end
        d2 = rand_data();
        in_pc = 32'h3054; in_bd = 1'b0; in_exc = 5'd12; in_data = d2; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (occupancy !== 2'd1 || out_exc !== 5'd12 || out_bd !== 1'b0 || out_pc !== 32'h3054 || out_data !== d2) begin
            bad++; $display("FAIL exc_pairing got occ=%0d exc=%0d bd=%0b pc=%h want 1 12 0 3054", occupancy, out_exc, out_bd, out_pc);
        end
        tick();
        in_exc = '0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1;
        in_pc = 32'h3060; tick();
        in_pc = 32'h3064; tick();
        reset = 1'b0; flush = 1'b1; flush_pc = 32'h3070; flush_bd = 1'b1;
        tick();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        total++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== RST_PC || out_bd !== 1'b0) begin
            bad++; $display("FAIL reset_mid got occ=%0d v=%0b rdy=%0b pc=%h bd=%0b want 0 0 1 3000 0",
                            occupancy, out_valid, in_ready, out_pc, out_bd);
        end
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_pc = 32'h4000 + 32'(i * 4); in_data = rand_data();
            tick();
            total++; if (out_valid !== 1'b1 || out_pc !== m_pc || out_data !== m_data) begin
                bad++; $display("FAIL reset_resume got v=%0b pc=%h want v=1 pc=%h", out_valid, out_pc, m_pc);
            end
        end
        in_valid = 1'b0; tick();
    endtask

    task automatic test_random();
        int nxfer;
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            flush_pc  = $urandom; flush_bd = 1'($urandom);
            in_data   = rand_data(); in_pc = $urandom; in_bd = 1'($urandom); in_exc = 5'($urandom);
            tick();
            total++; if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) || occupancy !== 2'(q.size())) begin
                bad++; $display("FAIL rand_ctrl cyc=%0d got v=%0b rdy=%0b occ=%0d want occ=%0d", i, out_valid, in_ready, occupancy, q.size());
            end
            total++; if (out_pc !== m_pc || out_bd !== m_bd || (q.size() > 0 && (out_data !== m_data || out_exc !== m_exc))) begin
                bad++; $display("FAIL rand_head cyc=%0d got pc=%h bd=%0b exc=%0d want pc=%h bd=%0b exc=%0d",
                                i, out_pc, out_bd, out_exc, m_pc, m_bd, m_exc);
            end
        end
        flush = 1'b0;
        nxfer = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            in_data = rand_data(); in_pc = $urandom;
            if (out_valid && out_ready) nxfer++;
            tick();
            total++; if (out_pc !== m_pc || out_data !== m_data) begin
                bad++; $display("FAIL rate_head cyc=%0d got pc=%h want pc=%h", i, out_pc, m_pc);
            end
        end
        total++; if (nxfer < 198) begin bad++; $display("FAIL full_rate got transfers=%0d want>=198", nxfer); end
    endtask

    initial begin
        #1;
        test_reset();
        test_pass_through();
        test_backpressure();
        test_flush();
        test_exception();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
